dmem_apb_responder: RTL and testbench
=====================================

# dmem_apb_responder

APB completer that models the data memory on the far side of the core's `dmem_apb` master port. It accepts the store and load transfers issued by the load/store unit, holds a word-addressed array with byte-strobe writes, and inserts a fixed number of wait states. It flags out-of-range accesses with PSLVERR. It is used as the dmem in core-level simulation and as the data RAM wrapper in the FPGA top.

## Interface

- `DAT_W`, 32: data width; only 32 is supported, which gives 4 byte strobes.
- `ADDR_W`, 32: APB address width.
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to 4*DEPTH_WORDS.
- `WAIT_STATES`, 0: number of access-phase cycles with PREADY low before completion; range 0..15.

Ports:

- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `psel` in 1: APB select.
- `penable` in 1: APB enable (access phase).
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_W: byte address; bits [1:0] are ignored.
- `pwdata` in DAT_W: write data.
- `pstrb` in 4: byte write strobes; ignored on reads.
- `prdata` out DAT_W: read data; valid only while a read is completing.
- `pready` out 1: transfer complete.
- `pslverr` out 1: error response; valid only while `pready`=1.
- `bd_we` in 1: backdoor word write, used for preload.
- `bd_addr` in $clog2(DEPTH_WORDS): backdoor word index.
- `bd_wdata` in DAT_W: backdoor data.
- `bd_busy` out 1: high when the FSM is not IDLE; backdoor writes are dropped while it is high.
- `err_count` out 8: saturating count of PSLVERR completions.

## Operation

- FSM states are IDLE and ACCESS.
- **IDLE, setup phase** (`psel`=1 and `penable`=0):
  - Capture `pwrite`, `pwdata`, `pstrb`, the word index ((paddr-BASE_ADDR)>>2) and the range flag. The range flag is `paddr` < BASE_ADDR or `paddr` ≥ BASE_ADDR+4*DEPTH_WORDS.
  - Read the array at the index into the internal read register. Out of range reads load 0.
  - Load the wait counter with WAIT_STATES and go to ACCESS.
- **IDLE, `penable`=1 without a preceding setup:** ignored, and the FSM stays in IDLE.
- **ACCESS:**
  - `pready` = (wait counter == 0).
  - While the counter is nonzero it decrements each cycle.
  - On `psel`&`penable`&`pready`:
    - An in-range write commits, updating the bytes whose `pstrb` bit is 1 (byte i = bits [8i+7:8i]).
    - An out-of-range access writes nothing, drives `pslverr`=1, and increments `err_count` (saturates at 255).
    - The FSM returns to IDLE.
- **ACCESS, `psel` drops before completion** (master protocol violation): abort to IDLE with no write, no error and no counter change.
- **Back-to-back transfers:** a new setup in the cycle right after completion is accepted from IDLE normally.
- **Read data path:**
  - `prdata` = read register when `pready`&~captured `pwrite`, else 0.
  - The array is not written between setup and completion of a read, so read data is never stale.
- **Backdoor:**
  - `bd_we` writes a full word when the FSM is IDLE and no setup is present in the same cycle.
  - Otherwise the backdoor write is dropped, and the APB setup wins.
- **Reset:**
  - Outputs and state: FSM IDLE, wait counter 0, read register 0, `err_count` 0, `pready` 0, `pslverr` 0, `prdata` 0, `bd_busy` 0.
  - Array contents are not reset.
  - `rst` mid-transfer abandons the transfer with no write.

## Timing

- Setup at cycle T → access phase at T+1. `pready` rises at T+1+WAIT_STATES.
- With WAIT_STATES=0 a transfer takes 2 cycles: setup, then access with `pready`=1.
- A write is visible to a setup issued at the cycle after completion.
- `pready`, `pslverr` and `prdata` depend only on registered state and captured fields, never combinationally on `pwdata`/`paddr`.
- `pready` is 0 in IDLE.
- `err_count` updates on the edge that ends the erroring transfer.

## Test plan

- **Preload and read:** preload word 5 = 32'hDEAD_BEEF via backdoor, then APB read 0x14 with WAIT_STATES=0 → `pready` at the access cycle, `prdata`=32'hDEAD_BEEF, `pslverr`=0.
- **Strobed write:** write 0x14 with `pwdata`=32'h1122_3344 and `pstrb`=4'b0101, then read it back → 32'hDE22_BE44.
- **Wait states:** with WAIT_STATES=3, a write followed by a back-to-back read → `pready` low for 3 access cycles each, and the read returns the written data.
- **Out-of-range access:** read BASE_ADDR+4*DEPTH_WORDS → `pslverr`=1, `prdata`=0, `err_count` 0→1. Then 300 erroring writes → `err_count`=255, and the array is unchanged.
- **Aborts:**
  - Drop `psel` during a wait-state access → no write, FSM back in IDLE, next transfer completes normally.
  - Assert `rst` mid-write → target word unchanged, all outputs at their reset values.
- **Backdoor conflict:** `bd_we` in the same cycle as an APB setup, or while `bd_busy`=1 → backdoor data is not written.

Source files
------------

// File: rtl/dmem_apb_responder.sv
// APB completer that stands in for the core's data memory: word-addressed array with
// byte-strobe writes, a fixed number of wait states, PSLVERR on out-of-range addresses.
module dmem_apb_responder #(
    parameter int unsigned              DAT_W       = 32,
    parameter int unsigned              ADDR_W      = 32,
    parameter int unsigned              DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0]        BASE_ADDR   = '0,
    parameter int unsigned              WAIT_STATES = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            psel,
    input  logic                            penable,
    input  logic                            pwrite,
    input  logic [ADDR_W-1:0]               paddr,
    input  logic [DAT_W-1:0]                pwdata,
    input  logic [3:0]                      pstrb,
    output logic [DAT_W-1:0]                prdata,
    output logic                            pready,
    output logic                            pslverr,
    input  logic                            bd_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0]  bd_addr,
    input  logic [DAT_W-1:0]                bd_wdata,
    output logic                            bd_busy,
    output logic [7:0]                      err_count
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned NBYTES = DAT_W / 8;

    // One extra bit so the window end cannot wrap when the array sits at the top of the map.
    localparam logic [ADDR_W:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] ADDR_HI = ADDR_LO + (ADDR_W+1)'(4 * DEPTH_WORDS);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state_reg;
    logic [3:0]         wait_cnt_reg;
    logic               pready_reg;
    logic               pwrite_reg;
    logic               range_err_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [DAT_W-1:0]   wdata_reg;
    logic [3:0]         strb_reg;
    logic [DAT_W-1:0]   rd_reg;
    logic [7:0]         err_count_reg;

    logic [DAT_W-1:0]   mem [DEPTH_WORDS];

    logic               setup;
    logic               complete;
    logic               range_err;
    logic [IDX_W-1:0]   setup_idx;
    logic               commit_wr;
    logic               bd_write;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [DAT_W-1:0]   wr_data;
    logic [NBYTES-1:0]  wr_be;

    assign setup     = (state_reg == IDLE) && psel && !penable;
    assign complete  = (state_reg == ACCESS) && psel && penable && pready_reg;
    assign range_err = ({1'b0, paddr} < ADDR_LO) || ({1'b0, paddr} >= ADDR_HI);
    assign setup_idx = IDX_W'((paddr - BASE_ADDR) >> 2);

    // APB commit and backdoor never coincide (ACCESS vs. IDLE), so one write port serves both.
    assign commit_wr = complete && pwrite_reg && !range_err_reg;
    assign bd_write  = bd_we && (state_reg == IDLE) && !(psel && !penable);
    assign wr_en     = !rst && (commit_wr || bd_write);
    assign wr_idx    = bd_write ? bd_addr : idx_reg;
    assign wr_data   = bd_write ? bd_wdata : wdata_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane_be
            assign wr_be[gi] = bd_write || strb_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            pready_reg    <= 1'b0;
            pwrite_reg    <= 1'b0;
            range_err_reg <= 1'b0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            strb_reg      <= '0;
            rd_reg        <= '0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (setup) begin
                        pwrite_reg    <= pwrite;
                        wdata_reg     <= pwdata;
                        strb_reg      <= pstrb;
                        idx_reg       <= setup_idx;
                        range_err_reg <= range_err;
                        rd_reg        <= range_err ? '0 : mem[setup_idx];
                        wait_cnt_reg  <= WAIT_INIT;
                        pready_reg    <= (WAIT_INIT == 4'd0);
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: nothing is written or counted.
                        state_reg    <= IDLE;
                        pready_reg   <= 1'b0;
                        wait_cnt_reg <= '0;
                    end else if (complete) begin
                        state_reg  <= IDLE;
                        pready_reg <= 1'b0;
                        if (range_err_reg && err_count_reg != 8'hFF) begin
                            err_count_reg <= err_count_reg + 8'd1;
                        end
                    end else if (wait_cnt_reg != 4'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        pready_reg   <= (wait_cnt_reg == 4'd1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pready    = pready_reg;
    assign pslverr   = pready_reg && range_err_reg;
    assign prdata    = (pready_reg && !pwrite_reg) ? rd_reg : '0;
    assign bd_busy   = (state_reg == ACCESS);
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_dmem_apb_responder.sv
// Drives two responders (0 and 3 wait states) with directed and random APB traffic
// and compares every completion against a word-array model of the memory.
module tb_dmem_apb_responder;

    localparam int DEPTH = 64;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb [2];
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];
    logic        bd_we [2];
    logic [5:0]  bd_addr [2];
    logic [31:0] bd_wdata [2];
    logic        bd_busy [2];
    logic [7:0]  err_count [2];

    logic [31:0] mem_m [2][DEPTH];
    int          err_m [2];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          fail_cnt = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dmem_apb_responder #(.DAT_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0),
                         .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .bd_we(bd_we[0]), .bd_addr(bd_addr[0]),
        .bd_wdata(bd_wdata[0]), .bd_busy(bd_busy[0]), .err_count(err_count[0]));

    dmem_apb_responder #(.DAT_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1),
                         .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .bd_we(bd_we[1]), .bd_addr(bd_addr[1]),
        .bd_wdata(bd_wdata[1]), .bd_busy(bd_busy[1]), .err_count(err_count[1]));

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input int k);
        check($sformatf("err_count%0d", k), 32'(err_count[k]), (err_m[k] > 255) ? 32'd255 : 32'(err_m[k]));
    endtask

    task automatic idle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; bd_we[k] = 1'b0;
        end
    endtask

    // One APB transfer; bd_mode 1 fires a backdoor write alongside setup, 2 during the access phase.
    task automatic apb(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int bd_mode);
        longint      off;
        bit          exp_err;
        int          idx;
        int          n;
        logic [31:0] exp_rd;
        off     = longint'(addr) - longint'(base_of(k));
        exp_err = (off < 0) || (off >= 4 * DEPTH);
        idx     = exp_err ? 0 : int'(off >>> 2);
        @(negedge clk);
        check("idle_pready", 32'(pready[k]), 32'd0);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = data; pstrb[k] = strb;
        if (bd_mode == 1) begin
            bd_we[k] = 1'b1; bd_addr[k] = 6'(idx); bd_wdata[k] = ~mem_m[k][idx];
        end
        @(negedge clk);
        penable[k] = 1'b1;
        bd_we[k] = 1'b0;
        check("access_busy", 32'(bd_busy[k]), 32'd1);
        if (bd_mode == 2) begin
            bd_we[k] = 1'b1; bd_addr[k] = 6'((idx + 1) % DEPTH); bd_wdata[k] = ~mem_m[k][(idx + 1) % DEPTH];
        end
        n = 0;
        while (pready[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            bd_we[k] = 1'b0;
            n++;
        end
        check("wait_states", 32'(n), 32'(ws_of(k)));
        exp_rd = (!wr && !exp_err) ? mem_m[k][idx] : 32'd0;
        check("prdata", prdata[k], exp_rd);
        check("pslverr", 32'(pslverr[k]), 32'(exp_err));
        last_rd = prdata[k];
        if (exp_err) begin
            err_m[k]++;
        end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_m[k][idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        $display("dut%0d %s addr=%08h wdata=%08h strb=%b rdata=%08h slverr=%0b waits=%0d",
                 k, wr ? "WR" : "RD", addr, data, strb, prdata[k], pslverr[k], n);
    endtask

    function automatic logic [31:0] rand_addr(input int k, input bit oor);
        if (!oor) return base_of(k) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        if (k == 1 && $urandom_range(0, 1) == 1) return 32'($urandom_range(0, 32'h1FFF));
        return base_of(k) + 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h0FFF_FFFF));
    endfunction

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = 0; pwdata[k] = 0; pstrb[k] = 0;
            bd_we[k] = 0; bd_addr[k] = 0; bd_wdata[k] = 0; err_m[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_pready", 32'(pready[k]), 32'd0);
            check("rst_pslverr", 32'(pslverr[k]), 32'd0);
            check("rst_prdata", prdata[k], 32'd0);
            check("rst_bd_busy", 32'(bd_busy[k]), 32'd0);
            check("rst_err_count", 32'(err_count[k]), 32'd0);
        end
        rst = 1'b0;

        // Preload both arrays; word 5 of dut0 holds DEADBEEF
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bd_we[k] = 1'b1; bd_addr[k] = 6'(i);
                bd_wdata[k] = (k == 0 && i == 5) ? 32'hDEAD_BEEF : $urandom();
                mem_m[k][i] = bd_wdata[k];
            end
        end
        idle();

        apb(0, 0, 32'h14, 32'h0, 4'h0, 0);
        check("preload_read", last_rd, 32'hDEAD_BEEF);
        apb(0, 1, 32'h14, 32'h1122_3344, 4'b0101, 0);
        apb(0, 0, 32'h14, 32'h0, 4'h0, 0);
        check("strobed_write", last_rd, 32'hDE22_BE44);

        a = $urandom();
        apb(1, 1, BASE1 + 32'h40, a, 4'hF, 0);
        apb(1, 0, BASE1 + 32'h40, 32'h0, 4'h0, 0);
        check("ws_readback", last_rd, a);
        idle();

        // Out-of-range: one read, then enough writes to saturate the counter
        check_err(0);
        apb(0, 0, BASE0 + 32'(4 * DEPTH), 32'h0, 4'h0, 0);
        idle();
        check("err_first", 32'(err_count[0]), 32'd1);
        for (int i = 0; i < 300; i++) apb(0, 1, rand_addr(0, 1), $urandom(), 4'($urandom()), 0);
        idle();
        check("err_saturated", 32'(err_count[0]), 32'd255);
        for (int i = 0; i < DEPTH; i++) apb(0, 0, BASE0 + 32'(4 * i), 32'h0, 4'h0, 0);
        idle();

        // psel dropped during wait states
        @(negedge clk);
        psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = BASE1 + 32'd28;
        pwdata[1] = ~mem_m[1][7]; pstrb[1] = 4'hF;
        @(negedge clk); penable[1] = 1;
        @(negedge clk); psel[1] = 0; penable[1] = 0;
        @(negedge clk);
        check("abort_busy", 32'(bd_busy[1]), 32'd0);
        check("abort_pready", 32'(pready[1]), 32'd0);
        apb(1, 0, BASE1 + 32'd28, 32'h0, 4'h0, 0);
        idle();
        check_err(1);

        // Reset on the completing edge of a write
        @(negedge clk);
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = BASE0 + 32'd36;
        pwdata[0] = ~mem_m[0][9]; pstrb[0] = 4'hF;
        @(negedge clk); penable[0] = 1; rst = 1'b1;
        @(negedge clk);
        check("midrst_pready", 32'(pready[0]), 32'd0);
        check("midrst_pslverr", 32'(pslverr[0]), 32'd0);
        check("midrst_prdata", prdata[0], 32'd0);
        check("midrst_busy", 32'(bd_busy[0]), 32'd0);
        check("midrst_err", 32'(err_count[0]), 32'd0);
        err_m[0] = 0; err_m[1] = 0;
        rst = 1'b0; psel[0] = 0; penable[0] = 0;
        apb(0, 0, BASE0 + 32'd36, 32'h0, 4'h0, 0);

        // Backdoor collisions: with a setup, and while busy
        apb(0, 0, BASE0 + 32'd48, 32'h0, 4'h0, 1);
        idle();
        apb(0, 0, BASE0 + 32'd48, 32'h0, 4'h0, 0);
        apb(1, 0, BASE1 + 32'd52, 32'h0, 4'h0, 2);
        idle();
        apb(1, 0, BASE1 + 32'd56, 32'h0, 4'h0, 0);

        // PENABLE without a setup is not a transfer
        @(negedge clk);
        psel[0] = 1; penable[0] = 1; pwrite[0] = 1; paddr[0] = BASE0; pwdata[0] = ~mem_m[0][0]; pstrb[0] = 4'hF;
        @(negedge clk);
        check("noset_busy", 32'(bd_busy[0]), 32'd0);
        idle();
        apb(0, 0, BASE0, 32'h0, 4'h0, 0);

        for (int i = 0; i < 200; i++) begin
            int k;
            k = $urandom_range(0, 1);
            apb(k, 1'($urandom()), rand_addr(k, $urandom_range(0, 7) == 0), $urandom(), 4'($urandom()), 0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        check_err(0);
        check_err(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
